// File: rtl/secuenciador_pkg.sv
// Shared constants and types for the beam configuration sequencer.
package secuenciador_pkg;

   localparam logic [1:0] MODE_STOP = 2'b00;
   localparam logic [1:0] MODE_RUN  = 2'b01;
   localparam logic [1:0] MODE_LOOP = 2'b10;
   localparam logic [1:0] MODE_STEP = 2'b11;

   localparam int unsigned DEFAULT_DEPTH    = 16;
   localparam int unsigned DEFAULT_STEP_DIV = 1;

   typedef enum logic {
      StIdle,
      StRunning
   } run_state_e;

endpackage

// File: rtl/secuenciador_mem.sv
// Sequence memory: DEPTH x 16 register array, synchronous write, asynchronous read.
module seq_mem #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [15:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [15:0]   rdata
);

   logic [15:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Combinational read sees pre-edge contents, giving read-before-write on collisions.
   assign rdata = mem[raddr];

endmodule

// File: rtl/secuenciador.sv
// Pattern sequencer: assembles host bytes into 16-bit entries and plays them onto
// theBeanConfig in stop / single run / loop / step modes.
module secuenciador
   import secuenciador_pkg::*;
#(
   parameter int unsigned DEPTH    = DEFAULT_DEPTH,
   parameter int unsigned STEP_DIV = DEFAULT_STEP_DIV
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        seq_en,
   input  logic [1:0]  mode,
   input  logic [7:0]  dato,
   input  logic        wr,
   output logic [15:0] theBeanConfig
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned LW = $clog2(DEPTH + 1);
   localparam int unsigned DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [LW-1:0] LEN_FULL = LW'(DEPTH);
   localparam logic [DW-1:0] DIV_LAST = DW'(STEP_DIV - 1);

   logic          seq_en_d;
   logic [1:0]    mode_q;
   logic          byte_sel_q;
   logic [7:0]    lo_hold_q;
   logic          wr_hi;
   logic [AW-1:0] wr_ptr_q;
   logic [LW-1:0] len_q;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d, rd_addr, rd_next;
   logic [DW-1:0] div_q, div_d;
   logic [15:0]   rd_data, cfg_q;
   logic          cfg_load;
   run_state_e    state_q, state_d;

   logic trig, mode_chg, go, start, stop_loop, running, tick, wrap;

   assign trig      = seq_en & ~seq_en_d;
   assign mode_chg  = (mode != mode_q);
   // A mode change swallows a coincident trigger; an empty memory ignores all triggers.
   assign go        = trig & ~mode_chg & (len_q != '0);
   assign running   = (state_q == StRunning);
   assign start     = go & ((mode == MODE_RUN) | ((mode == MODE_LOOP) & ~running));
   assign stop_loop = go & (mode == MODE_LOOP) & running;
   assign tick      = running & (div_q == DIV_LAST);
   assign wrap      = (LW'(rd_ptr_q) + LW'(1)) >= len_q;
   assign rd_next   = wrap ? '0 : rd_ptr_q + AW'(1);

   // Byte assembler, write pointer and entry count
   assign wr_hi = wr & byte_sel_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_sel_q <= 1'b0;
         lo_hold_q  <= '0;
         wr_ptr_q   <= '0;
         len_q      <= '0;
      end else if (wr) begin
         byte_sel_q <= ~byte_sel_q;
         if (!byte_sel_q) begin
            lo_hold_q <= dato;
         end else begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
            if (len_q != LEN_FULL) begin
               len_q <= len_q + LW'(1);
            end
         end
      end
   end

   seq_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (wr_hi),
      .waddr (wr_ptr_q),
      .wdata ({dato, lo_hold_q}),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   // Run control FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Run control FSM: next state
   always_comb begin
      state_d = state_q;
      if (mode_chg) begin
         state_d = StIdle;
      end else if (start) begin
         // A single run over one entry finishes on its trigger edge.
         state_d = ((mode == MODE_RUN) && (len_q == LW'(1))) ? StIdle : StRunning;
      end else if (stop_loop) begin
         state_d = StIdle;
      end else if (tick && (mode == MODE_RUN) && wrap) begin
         state_d = StIdle;
      end
   end

   // Run control FSM: datapath controls
   always_comb begin
      cfg_load = 1'b0;
      rd_addr  = rd_ptr_q;
      rd_ptr_d = rd_ptr_q;
      div_d    = div_q;
      if (mode_chg) begin
         rd_ptr_d = '0;
         div_d    = '0;
      end else if (go && (mode == MODE_STEP)) begin
         cfg_load = 1'b1;
         rd_ptr_d = rd_next;
      end else if (start) begin
         cfg_load = 1'b1;
         rd_addr  = '0;
         rd_ptr_d = (len_q == LW'(1)) ? '0 : AW'(1);
         div_d    = '0;
      end else if (stop_loop) begin
         div_d = '0;
      end else if (running) begin
         if (tick) begin
            cfg_load = 1'b1;
            rd_ptr_d = rd_next;
            div_d    = '0;
         end else begin
            div_d = div_q + DW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seq_en_d <= 1'b0;
         mode_q   <= MODE_STOP;
         rd_ptr_q <= '0;
         div_q    <= '0;
         cfg_q    <= '0;
      end else begin
         seq_en_d <= seq_en;
         mode_q   <= mode;
         rd_ptr_q <= rd_ptr_d;
         div_q    <= div_d;
         if (cfg_load) begin
            cfg_q <= rd_data;
         end
      end
   end

   assign theBeanConfig = cfg_q;

endmodule

// File: tb/tb_secuenciador.sv
// Self-checking bench: directed scenarios with literal expectations plus a random
// phase, all checked every cycle against a behavioural model of the sequencer.
module tb_secuenciador;

   localparam int DEPTH    = 16;
   localparam int STEP_DIV = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        seq_en = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic [7:0]  dato = 8'h00;
   logic        wr = 1'b0;
   logic [15:0] theBeanConfig;

   int n_tests = 0;
   int n_fail  = 0;

   secuenciador #(
      .DEPTH    (DEPTH),
      .STEP_DIV (STEP_DIV)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .seq_en        (seq_en),
      .mode          (mode),
      .dato          (dato),
      .wr            (wr),
      .theBeanConfig (theBeanConfig)
   );

   always #5 clk = ~clk;

   // Behavioural model state
   logic [15:0] m_mem [DEPTH];
   logic [15:0] m_out;
   logic [7:0]  m_lo;
   logic [1:0]  m_mode_prev;
   bit          m_en_prev, m_sel, m_run;
   int          m_len, m_wp, m_rd, m_div;
   int          cyc = 0;

   function automatic void model_reset();
      m_out = 16'h0000; m_lo = 8'h00; m_mode_prev = 2'b00; m_en_prev = 1'b0;
      m_sel = 1'b0; m_run = 1'b0; m_len = 0; m_wp = 0; m_rd = 0; m_div = 0;
   endfunction

   function automatic void model_step();
      bit trig, chg;
      trig = seq_en && !m_en_prev;
      chg  = (mode != m_mode_prev);
      // Playback uses memory contents from before this edge's write.
      if (chg) begin
         m_run = 1'b0; m_rd = 0; m_div = 0;
      end else if (trig && m_len > 0 && mode == 2'b11) begin
         m_out = m_mem[m_rd];
         m_rd  = (m_rd + 1) % m_len;
      end else if (trig && m_len > 0 && (mode == 2'b01 || (mode == 2'b10 && !m_run))) begin
         m_out = m_mem[0];
         m_rd  = 1 % m_len;
         m_div = 0;
         m_run = !(mode == 2'b01 && m_len == 1);
      end else if (trig && m_len > 0 && mode == 2'b10) begin
         m_run = 1'b0; m_div = 0;
      end else if (m_run) begin
         if (m_div == STEP_DIV - 1) begin
            m_out = m_mem[m_rd];
            m_div = 0;
            if (mode == 2'b01 && m_rd == m_len - 1) m_run = 1'b0;
            m_rd = (m_rd + 1) % m_len;
         end else begin
            m_div = m_div + 1;
         end
      end
      if (wr) begin
         if (!m_sel) begin
            m_lo = dato;
         end else begin
            m_mem[m_wp] = {dato, m_lo};
            m_wp  = (m_wp + 1) % DEPTH;
            m_len = (m_len < DEPTH) ? m_len + 1 : DEPTH;
         end
         m_sel = !m_sel;
      end
      m_en_prev   = seq_en;
      m_mode_prev = mode;
   endfunction

   // Compare process: model advances on every edge, DUT checked just after.
   always begin
      @(posedge clk or posedge rst);
      if (rst) begin
         model_reset();
      end else begin
         model_step();
         cyc++;
         #1;
         n_tests++;
         if (theBeanConfig !== m_out) begin
            n_fail++;
            $display("FAIL model cycle %0d: theBeanConfig=%h expected %h", cyc, theBeanConfig,
                     m_out);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string name, input logic [15:0] exp);
      n_tests++;
      if (theBeanConfig !== exp) begin
         n_fail++;
         $display("FAIL %s: theBeanConfig=%h expected %h", name, theBeanConfig, exp);
      end
   endtask

   task automatic pulse(input string name, input logic [15:0] exp);
      seq_en = 1'b1;
      tick();
      check(name, exp);
      seq_en = 1'b0;
      tick();
   endtask

   task automatic write_byte(input logic [7:0] b);
      wr = 1'b1; dato = b;
      tick();
      wr = 1'b0;
   endtask

   logic [15:0] exp_step [6] = '{16'h0201, 16'h0403, 16'h0605, 16'h0807, 16'h0201, 16'h0403};
   logic [15:0] exp_run  [8] = '{16'h0201, 16'h0403, 16'h0605, 16'h0807,
                                 16'h0807, 16'h0807, 16'h0807, 16'h0807};

   initial begin
      repeat (2) tick();
      check("reset", 16'h0000);
      rst = 1'b0;
      tick();

      // Empty memory: triggers in every mode do nothing
      for (int m = 0; m < 4; m++) begin
         mode = 2'(m);
         tick();
         pulse("empty", 16'h0000);
      end
      mode = 2'b00;
      tick();

      // Byte assembly: 01..08 with wr held high
      wr = 1'b1;
      for (int b = 1; b <= 8; b++) begin
         dato = 8'(b);
         tick();
      end
      wr = 1'b0;

      // Step with wrap at len
      mode = 2'b11;
      tick();
      for (int i = 0; i < 6; i++) pulse("step", exp_step[i]);

      // Single run with held seq_en
      mode = 2'b01;
      tick();
      seq_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("run", exp_run[i]);
      end
      seq_en = 1'b0;
      tick();

      // Loop, stop by trigger, restart, stop by mode change
      mode = 2'b10;
      tick();
      seq_en = 1'b1;
      tick();
      check("loop_first", 16'h0201);
      seq_en = 1'b0;
      repeat (5) tick();
      check("loop_wrap", 16'h0403);
      seq_en = 1'b1;
      tick();
      check("loop_stop", 16'h0403);
      seq_en = 1'b0;
      repeat (3) tick();
      check("loop_hold", 16'h0403);
      pulse("loop_restart", 16'h0201);
      tick();
      check("loop_run", 16'h0605);
      mode = 2'b00;
      tick();
      repeat (2) tick();
      check("mode_chg_hold", 16'h0605);
      mode = 2'b11;
      tick();
      pulse("rd_cleared", 16'h0201);

      // Overflow: bytes 09..36 bring the total to 18 entries
      mode = 2'b00;
      tick();
      for (int b = 9; b <= 36; b++) write_byte(8'(b));
      mode = 2'b11;
      tick();
      pulse("ovf_e0", 16'h2221);
      pulse("ovf_e1", 16'h2423);
      pulse("ovf_e2", 16'h0605);
      for (int j = 3; j < 16; j++) pulse("ovf_mid", {8'(2 * j + 2), 8'(2 * j + 1)});
      pulse("ovf_wrap16", 16'h2221);
      pulse("ovf_e1b", 16'h2423);

      // Read and write of entry 2 on the same edge
      wr = 1'b1; dato = 8'hAA;
      tick();
      dato = 8'hBB; seq_en = 1'b1;
      tick();
      check("rbw_old", 16'h0605);
      wr = 1'b0; seq_en = 1'b0;
      tick();
      mode = 2'b00;
      tick();
      mode = 2'b11;
      tick();
      pulse("rbw_e0", 16'h2221);
      pulse("rbw_e1", 16'h2423);
      pulse("rbw_new", 16'hBBAA);

      // Asynchronous reset mid-loop with a half-assembled pair pending
      mode = 2'b10;
      tick();
      seq_en = 1'b1; wr = 1'b1; dato = 8'h77;
      tick();
      seq_en = 1'b0; wr = 1'b0;
      repeat (2) tick();
      #2 rst = 1'b1;
      #1 check("async_rst", 16'h0000);
      tick();
      rst = 1'b0;
      mode = 2'b11;
      tick();
      write_byte(8'h11);
      write_byte(8'h22);
      pulse("post_rst", 16'h2211);
      pulse("post_rst_wrap", 16'h2211);

      // Random phase
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < 3) mode = 2'($urandom_range(0, 3));
         seq_en = ($urandom_range(0, 99) < 35);
         wr     = ($urandom_range(0, 99) < 20);
         dato   = 8'($urandom);
         tick();
      end
      seq_en = 1'b0; wr = 1'b0;
      tick();
      #2;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
